// File: rtl/synapse_accumulator.sv
// Synaptic weighting stage: snapshots N_PRE spike bits and sums one signed weight per set bit, one bit per cycle.
// Optional macro SYN_SAT_EN: the accumulator saturates to the signed 16-bit range instead of wrapping.
module synapse_accumulator #(
    parameter int                 N_PRE    = 8,
    parameter logic signed [15:0] W_RST    = 16'sh0010,
    parameter int                 T_WINDOW = 250,
    localparam int                AW       = (N_PRE > 1) ? $clog2(N_PRE) : 1,
    localparam int                CW       = (T_WINDOW > 1) ? $clog2(T_WINDOW) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_PRE-1:0] pre_spike,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [15:0]      wr_data,
    output logic             busy,
    output logic [15:0]      spiking_value,
    output logic             value_valid,
    output logic             window_done
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [N_PRE-1:0] snap_reg;
    logic [AW-1:0]    idx_reg;
    logic [15:0]      acc_reg;
    logic [15:0]      acc_next;
    logic [15:0]      weight_sel;
    logic [CW-1:0]    win_cnt_reg;
    logic             last_idx;
    logic [15:0]      weight_arr [N_PRE];

    // Weights need a reset value, so they live in flops rather than block RAM.
    // Addresses >= N_PRE never match any gi, so such writes fall away.
    genvar gi;
    generate
        for (gi = 0; gi < N_PRE; gi++) begin : g_weight
            logic [15:0] weight_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    weight_reg <= W_RST;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    weight_reg <= wr_data;
                end
            end

            assign weight_arr[gi] = weight_reg;
        end
    endgenerate

    // A write landing on the scanned index this cycle is not yet visible here.
    assign weight_sel = weight_arr[idx_reg];
    assign last_idx   = (idx_reg == AW'(N_PRE - 1));
    assign busy       = (state_reg != IDLE);

`ifdef SYN_SAT_EN
    logic [16:0] sum_wide;

    always_comb begin
        sum_wide = {acc_reg[15], acc_reg} + {weight_sel[15], weight_sel};
        if (sum_wide[16] != sum_wide[15]) begin
            acc_next = sum_wide[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            acc_next = sum_wide[15:0];
        end
    end
`else
    assign acc_next = acc_reg + weight_sel;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en) state_next = SCAN;
            SCAN:    if (last_idx) state_next = EMIT;
            EMIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_reg      <= '0;
            idx_reg       <= '0;
            acc_reg       <= '0;
            win_cnt_reg   <= '0;
            spiking_value <= '0;
            value_valid   <= 1'b0;
            window_done   <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            window_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        snap_reg <= pre_spike;
                        acc_reg  <= '0;
                        idx_reg  <= '0;
                    end
                end
                SCAN: begin
                    if (snap_reg[idx_reg]) begin
                        acc_reg <= acc_next;
                    end
                    idx_reg <= idx_reg + AW'(1);
                end
                EMIT: begin
                    spiking_value <= acc_reg;
                    value_valid   <= 1'b1;
                    if (win_cnt_reg == CW'(T_WINDOW - 1)) begin
                        win_cnt_reg <= '0;
                        window_done <= 1'b1;
                    end else begin
                        win_cnt_reg <= win_cnt_reg + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Randomized self-checking bench for synapse_accumulator against a plain-arithmetic reference model.
// Build with +define+SYN_SAT_EN to check the saturating variant.
module tb_synapse_accumulator;

    localparam int N  = 8;
    localparam int T  = 250;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  pre_spike;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic [15:0]   spiking_value;
    logic          value_valid;
    logic          window_done;

    int checks = 0;
    int errors = 0;
    int emit_cnt = 0;
    int done_seen = 0;
    int w [N];
    int exp_q [$];

    synapse_accumulator #(
        .N_PRE   (N),
        .W_RST   (16'sh0010),
        .T_WINDOW(T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .pre_spike    (pre_spike),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .spiking_value(spiking_value),
        .value_valid  (value_valid),
        .window_done  (window_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_sum(input logic [N-1:0] s);
        int acc;
        logic [15:0] t;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            if (s[i]) begin
                acc += w[i];
`ifdef SYN_SAT_EN
                if (acc > 32767)  acc = 32767;
                if (acc < -32768) acc = -32768;
`endif
            end
        end
        t = acc[15:0];
        return int'($signed(t));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) w[i] = 16;
    endfunction

    // Every emitted sum is matched in order; window_done is judged from the emission count since reset.
    always @(negedge clk) begin
        if (!rst) begin
            emit_cnt = 0;
        end else if (value_valid) begin
            emit_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                check("sum", int'($signed(spiking_value)), exp_q.pop_front());
            end
            check("window_done", int'(window_done), (emit_cnt % T == 0) ? 1 : 0);
            if (window_done) done_seen++;
        end else begin
            check("window_done_idle", int'(window_done), 0);
        end
    end

    task automatic apply_reset(input int cycles);
        rst = 1'b0;
        exp_q.delete();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (a < N) w[a] = int'($signed(d));
    endtask

    // One sum from IDLE; optionally a weight write strobed before edge wr_k after the accepting edge.
    task automatic do_sum(input logic [N-1:0] snap, input int wr_k, input int wr_a, input logic [15:0] wr_d);
        bit got;
        en        = 1'b1;
        pre_spike = snap;
        exp_q.push_back(model_sum(snap));
        @(posedge clk);
        #1;
        en        = 1'b0;
        pre_spike = N'($urandom);
        got       = 1'b0;
        for (int k = 1; k <= N + 4 && !got; k++) begin
            check("busy_scan", int'(busy), 1);
            wr_en = (k == wr_k);
            if (k == wr_k) begin
                wr_addr = AW'(wr_a);
                wr_data = wr_d;
            end
            @(posedge clk);
            #1;
            if (k == wr_k) begin
                wr_en = 1'b0;
                w[wr_a] = int'($signed(wr_d));
            end
            pre_spike = N'($urandom);
            if (value_valid) begin
                got = 1'b1;
                check("latency", k, N + 1);
                check("busy_after", int'(busy), 0);
            end
        end
        if (!got) check("valid_timeout", 0, 1);
    endtask

    // en held high with pre_spike changing every cycle: accepts land every N+2 cycles.
    task automatic stream(input int n_sums);
        en = 1'b1;
        pre_spike = N'($urandom);
        for (int c = 0; c < n_sums * (N + 2); c++) begin
            if (c % (N + 2) == 0) exp_q.push_back(model_sum(pre_spike));
            @(posedge clk);
            #1;
            check("stream_valid", int'(value_valid), (c % (N + 2) == N + 1) ? 1 : 0);
            pre_spike = N'($urandom);
        end
        en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        en = 1'b0; pre_spike = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        apply_reset(3);
        check("rst_value", int'(spiking_value), 0);
        check("rst_valid", int'(value_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wdone", int'(window_done), 0);

        do_sum(8'b0000_0101, -1, 0, 16'h0);

        wr(0, 16'd100);
        wr(3, 16'hFFD8);
        wr(7, 16'd5);
        do_sum(8'b1000_1001, -1, 0, 16'h0);
        do_sum(8'h00, -1, 0, 16'h0);

        for (int i = 0; i < N; i++) wr(i, 16'h7000);
        do_sum(8'hFF, -1, 0, 16'h0);

        stream(4);
        repeat (N + 3) @(posedge clk);
        #1;

        wr(2, 16'd16);
        do_sum(8'b0000_0100, 3, 2, 16'd1000);
        do_sum(8'b0000_0100, -1, 0, 16'h0);

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 1) == 1) wr(int'($urandom_range(0, N - 1)), 16'($urandom));
            do_sum(N'($urandom), -1, 0, 16'h0);
        end

        // Abort a scan at idx=4: outputs clear at once and weights return to their reset value.
        en = 1'b1; pre_spike = 8'hFF;
        exp_q.push_back(model_sum(8'hFF));
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_before_abort", int'(busy), 1);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("abort_value", int'(spiking_value), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(value_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_valid", int'(value_valid), 0);
        end
        do_sum(8'hFF, -1, 0, 16'h0);

        apply_reset(2);
        d0 = done_seen;
        stream(T + 5);
        repeat (N + 3) @(posedge clk);
        #1;
        check("window_done_count", done_seen - d0, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/synapse_accumulator.md
Name: synapse_accumulator

Overview:
- Synaptic weighting stage between the input_neuron array and exc_neuron.
- Each time `en` is asserted, it snapshots the N_PRE pre-synaptic spike bits.
- It then scans them one per cycle, summing a programmable signed weight for each set bit.
- It presents the sum as the signed 16-bit `spiking_value`, with a one-cycle valid strobe that drives the exc_neuron `en`. It also counts emissions to mark T_WINDOW boundaries.

Parameters:
- N_PRE, 8, number of pre-synaptic inputs (2..64).
- W_RST, 16'sh0010, reset value of every weight register.
- T_WINDOW, 250, number of emitted sums per observation window.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low: all state clears while rst=0.
- en  input  1  start request; sampled only in IDLE.
- pre_spike  input  N_PRE  spike bits from the input_neuron outputs.
- wr_en  input  1  weight write strobe.
- wr_addr  input  clog2(N_PRE)  weight index to write.
- wr_data  input  16  signed weight value.
- busy  output  1  high in SCAN and EMIT.
- spiking_value  output  16  signed weighted sum; holds its value between emissions.
- value_valid  output  1  one-cycle strobe when spiking_value updates.
- window_done  output  1  one-cycle strobe on the T_WINDOW-th emission.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; accumulator, index, and window counter go to 0.
  - All weights go to W_RST.
  - spiking_value=0, value_valid=0, busy=0, window_done=0.
  - A reset during SCAN or EMIT aborts the operation; no value_valid is issued.
- IDLE:
  - en=1 captures pre_spike into a snapshot register, clears the accumulator and index, and moves to SCAN.
  - en=0 leaves the state in IDLE.
- SCAN, one index per cycle for idx = 0..N_PRE-1:
  - If snap[idx]=1, acc <= acc + weight[idx], using a 17-bit internal sum.
  - At idx=N_PRE-1, move to EMIT.
  - Snapshot bits that are 0 still consume their cycle; there is no skipping.
- EMIT (one cycle):
  - spiking_value <= acc; value_valid=1.
  - Window counter increments. If it reaches T_WINDOW-1, window_done=1 and the counter wraps to 0.
  - State returns to IDLE.
- Latency: en accepted at cycle 0 gives value_valid at cycle N_PRE+1 (registered). Next en is accepted the cycle after EMIT, so maximum throughput is one sum per N_PRE+2 cycles.
- en while busy=1 is ignored. Changes on pre_spike during SCAN are ignored because only the snapshot is used.
- Weight writes:
  - Accepted in every state; the write takes effect at the clock edge.
  - If a write targets the index being scanned in the same cycle, the scan uses the old weight.
  - wr_addr >= N_PRE is ignored.
- Arithmetic:
  - Weights are two's complement.
  - Sum overflow handling depends on SYN_SAT_EN (see Optional Feature).
  - The all-zero snapshot emits 0.

Optional Feature:
- Macro: SYN_SAT_EN.
- Defined:
  - After each addition, the accumulator saturates to [-32768, 32767] before the next addition.
  - A sticky saturation flag is not exported; the clamped value is simply retained.
- Undefined: the accumulator is 16-bit and wraps modulo 2^16. No saturation logic is generated.

Test Plan:
1. Reset, then check defaults: hold rst=0 for 3 cycles, release, pulse en with pre_spike=8'b0000_0101 → value_valid exactly at cycle 9 after en, spiking_value=16'sh0020, busy high for cycles 1..9.
2. Programmed weights: write w0=100, w3=-40, w7=5; en with pre_spike=8'b1000_1001 → spiking_value=65; en with pre_spike=8'h00 → 0.
3. Overflow: set all weights to 16'sh7000, en with pre_spike=8'hFF.
   - SYN_SAT_EN defined → spiking_value=32767.
   - Undefined → spiking_value=16'h8000, the wrapped sum.
4. Busy/snapshot: en accepted, then en held high and pre_spike toggled during SCAN → exactly one value_valid per N_PRE+2 cycles, each sum equal to its snapshot.
5. Write collision: during SCAN at idx=2, write w2=1000 with old w2=16 and pre_spike bit2 set → that emission uses 16, the next emission uses 1000.
6. Window and mid-operation reset:
   - 250 back-to-back emissions → window_done high only with the 250th value_valid, then the count restarts.
   - rst=0 asserted at SCAN idx=4 → outputs clear immediately, no value_valid, weights back to W_RST.
